// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: register offsets and STATUS/CTRL bit positions for periph_bus_responder
//   no ports; imported by periph_bus_responder
package periph_bus_pkg;
    typedef enum logic [3:0] {
        OFF_CTRL   = 4'd0,
        OFF_STATUS = 4'd1,
        OFF_DIN    = 4'd2,
        OFF_DOUT   = 4'd3,
        OFF_CFG    = 4'd4,
        OFF_CLR    = 4'd5
    } off_e;
    localparam int CTRL_START    = 0;
    localparam int CTRL_SOFT_CLR = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int ST_BUSY       = 0;
    localparam int ST_DONE       = 1;
    localparam int ST_IN_FULL    = 2;
    localparam int ST_IN_EMPTY   = 3;
    localparam int ST_OUT_FULL   = 4;
    localparam int ST_OUT_EMPTY  = 5;
    localparam int ST_ERR        = 6;
endpackage

// File: rtl/periph_bus_responder_if.sv
// periph_bus_responder_if: single-cycle CPU bus (valid/write/addr/wdata/rdata)
//   master drives valid/write/addr/wdata and samples rdata; slave the reverse
interface periph_bus_responder_if #(parameter int DATA_W = 19, parameter int ADDR_W = 19);
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    modport master (output valid, write, addr, wdata, input rdata);
    modport slave  (input valid, write, addr, wdata, output rdata);
endinterface

// File: rtl/periph_bus_responder_sync_fifo.sv
// sync_fifo: power-of-2 deep synchronous FIFO with flush and show-ahead head data
//   clk, rst_n (async active-low); push/din, pop/dout, flush; full/empty status
module sync_fifo #(parameter int DATA_W = 19, parameter int DEPTH = 4) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;
    logic              do_push, do_pop;
    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign dout    = mem[rp];
    assign do_pop  = pop & !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (!full | pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= do_push ? wp + PW'(1) : wp;
            rp  <= do_pop ? rp + PW'(1) : rp;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp] <= din;
    end
endmodule

// File: rtl/periph_bus_responder.sv
// periph_bus_responder: CPU bus slave exposing regs, in/out FIFOs and start/done to an accelerator
//   clk, rst_n (async active-low); bus (slave modport); acc_start/acc_cfg/acc_busy/acc_done;
//   acc_in_* stream out of the input FIFO; acc_out_* stream into the output FIFO;
//   irq only when PERIPH_IRQ_EN is defined
module periph_bus_responder
    import periph_bus_pkg::*;
#(
    parameter int DATA_W     = 19,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    periph_bus_responder_if.slave    bus,
    output logic                     acc_start,
    output logic [DATA_W-1:0]        acc_cfg,
    input  logic                     acc_busy,
    input  logic                     acc_done,
    output logic [DATA_W-1:0]        acc_in_data,
    output logic                     acc_in_valid,
    input  logic                     acc_in_ready,
    input  logic [DATA_W-1:0]        acc_out_data,
    input  logic                     acc_out_valid,
    output logic                     acc_out_ready
`ifdef PERIPH_IRQ_EN
    ,
    output logic                     irq
`endif
);
    logic [3:0]        off;
    logic              wr, rd, ctrl_wr, soft_clr, start_req, din_wr, dout_rd, clr_wr, cfg_wr;
    logic              in_full, in_empty, out_full, out_empty, in_pop, out_push;
    logic              done, err, done_nxt, err_nxt, err_set;
    logic [DATA_W-1:0] cfg, out_head, status, ctrl_rd;
    logic              unused_addr;
    assign unused_addr = ^bus.addr[ADDR_W-1:4];
    assign off       = bus.addr[3:0];
    assign wr        = bus.valid & bus.write;
    assign rd        = bus.valid & !bus.write;
    assign ctrl_wr   = wr & (off == OFF_CTRL);
    assign soft_clr  = ctrl_wr & bus.wdata[CTRL_SOFT_CLR];
    assign start_req = ctrl_wr & bus.wdata[CTRL_START];
    assign din_wr    = wr & (off == OFF_DIN);
    assign dout_rd   = rd & (off == OFF_DOUT);
    assign clr_wr    = wr & (off == OFF_CLR);
    assign cfg_wr    = wr & (off == OFF_CFG);
    assign acc_in_valid  = !in_empty;
    assign acc_out_ready = !out_full;
    assign in_pop        = acc_in_valid & acc_in_ready;
    assign out_push      = acc_out_valid & acc_out_ready;
    assign acc_cfg       = cfg;
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(clk), .rst_n(rst_n), .push(din_wr), .pop(in_pop), .flush(soft_clr),
        .din(bus.wdata), .dout(acc_in_data), .full(in_full), .empty(in_empty)
    );
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk(clk), .rst_n(rst_n), .push(out_push), .pop(dout_rd), .flush(soft_clr),
        .din(acc_out_data), .dout(out_head), .full(out_full), .empty(out_empty)
    );
    assign err_set  = (start_req & acc_busy) | (din_wr & in_full & !in_pop) | (dout_rd & out_empty);
    // new events win over a same-cycle W1C; soft_clr wins over everything
    assign done_nxt = soft_clr ? 1'b0 : acc_done | (done & !(clr_wr & bus.wdata[ST_DONE]));
    assign err_nxt  = soft_clr ? 1'b0 : err_set | (err & !(clr_wr & bus.wdata[ST_ERR]));
    assign status   = DATA_W'({err, out_empty, out_full, in_empty, in_full, done, acc_busy});
`ifdef PERIPH_IRQ_EN
    logic irq_en, irq_en_nxt;
    assign irq_en_nxt = ctrl_wr ? bus.wdata[CTRL_IRQ_EN] : irq_en;
    assign ctrl_rd    = DATA_W'({irq_en, 2'b00});
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_nxt;
            irq    <= irq_en_nxt & (done_nxt | err_nxt);
        end
    end
`else
    assign ctrl_rd = '0;
`endif
    always_comb begin
        bus.rdata = !rd                  ? '0 :
                    (off == OFF_CTRL)    ? ctrl_rd :
                    (off == OFF_STATUS)  ? status :
                    (off == OFF_DOUT)    ? (out_empty ? '0 : out_head) :
                    (off == OFF_CFG)     ? cfg : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            acc_start <= 1'b0;
        end else begin
            cfg       <= cfg_wr ? bus.wdata : cfg;
            done      <= done_nxt;
            err       <= err_nxt;
            acc_start <= start_req & !acc_busy;
        end
    end
endmodule
